// File: rtl/coin_pkg.sv
// Shared definitions for the change dispenser: coin values in nickel units,
// the controller state encoding, the coin selector encoding, and a helper
// that maps a coin to its value.
package coin_pkg;

  localparam int unsigned NICKEL_UNITS  = 32'd1;
  localparam int unsigned DIME_UNITS    = 32'd2;
  localparam int unsigned QUARTER_UNITS = 32'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } disp_state_t;

  typedef enum logic [1:0] {
    COIN_N = 2'd0,
    COIN_D = 2'd1,
    COIN_Q = 2'd2
  } coin_t;

  // Value of a coin in nickel units.
  function automatic int unsigned coin_units(input coin_t coin);
    case (coin)
      COIN_Q:  return QUARTER_UNITS;
      COIN_D:  return DIME_UNITS;
      COIN_N:  return NICKEL_UNITS;
      default: return NICKEL_UNITS;
    endcase
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counter shared by the PULSE and GAP phases of the change dispenser.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        reload the counter this cycle
//   load_gap    selects the reload length: 1 = GAP_CYCLES, 0 = PULSE_CYCLES
//   expire      high during the last cycle of the loaded interval
module pulse_timer
  import coin_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_gap,
  output logic expire
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;

  // Load length-1 so that the count reaching zero marks the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_gap ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(PULSE_CYCLES - 1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return controller: accepts a change amount (nickel units) over a
// valid/ready handshake and pays it out greedily as timed solenoid pulses,
// falling back to smaller coins when a tube is empty.
// Build option: CHANGE_DISPENSER_QUARTER_EN enables the quarter branch;
// without it quarter_out is tied low and quarter_empty is ignored.
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   req_valid/req_ready/req_amount       change request handshake
//   quarter_empty/dime_empty/nickel_empty tube-empty flags, looked at in SELECT
//   quarter_out/dime_out/nickel_out      registered solenoid drives (one-hot or zero)
//   busy                                 high whenever not idle
//   done/err/rem_out                     completion strobe, failure flag, remainder
module change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W        = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             quarter_empty,
  input  logic             dime_empty,
  input  logic             nickel_empty,
  output logic             quarter_out,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] rem_out
);

  disp_state_t      state_r, state_next;
  coin_t            coin_r, coin_next, pick_coin;
  logic [AMT_W-1:0] rem_r, rem_next;
  logic             pick, err_next;
  logic             tmr_load, tmr_gap, tmr_expire;

  pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_gap(tmr_gap),
    .expire  (tmr_expire)
  );

  // Greedy coin choice from the current remainder and tube flags.
  always_comb begin
    pick      = 1'b0;
    pick_coin = COIN_N;
    if (rem_r == '0) begin
      pick = 1'b0;
    end
`ifdef CHANGE_DISPENSER_QUARTER_EN
    else if (rem_r >= AMT_W'(QUARTER_UNITS) && !quarter_empty) begin
      pick      = 1'b1;
      pick_coin = COIN_Q;
    end
`endif
    else if (rem_r >= AMT_W'(DIME_UNITS) && !dime_empty) begin
      pick      = 1'b1;
      pick_coin = COIN_D;
    end else if (rem_r >= AMT_W'(NICKEL_UNITS) && !nickel_empty) begin
      pick      = 1'b1;
      pick_coin = COIN_N;
    end else begin
      pick      = 1'b0;
      pick_coin = COIN_N;
    end
  end

  // Next-state, remainder and timer control.
  always_comb begin
    state_next = state_r;
    rem_next   = rem_r;
    coin_next  = coin_r;
    err_next   = 1'b0;
    tmr_load   = 1'b0;
    tmr_gap    = 1'b0;
    case (state_r)
      IDLE: begin
        // req_ready is exactly "state is IDLE", so req_valid alone decides.
        if (req_valid) begin
          state_next = SELECT;
          rem_next   = req_amount;
        end else begin
          state_next = IDLE;
        end
      end
      SELECT: begin
        if (pick) begin
          state_next = PULSE;
          coin_next  = pick_coin;
          // Chosen coin never exceeds the remainder, so no underflow.
          rem_next   = rem_r - AMT_W'(coin_units(pick_coin));
          tmr_load   = 1'b1;
          tmr_gap    = 1'b0;
        end else begin
          state_next = DONE;
          err_next   = (rem_r != '0);
        end
      end
      PULSE: begin
        if (tmr_expire) begin
          state_next = GAP;
          tmr_load   = 1'b1;
          tmr_gap    = 1'b1;
        end else begin
          state_next = PULSE;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          state_next = SELECT;
        end else begin
          state_next = GAP;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and remainder registers; outputs are registered decodes of the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rem_r      <= '0;
      coin_r     <= COIN_N;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rem_out    <= '0;
      dime_out   <= 1'b0;
      nickel_out <= 1'b0;
    end else begin
      state_r    <= state_next;
      rem_r      <= rem_next;
      coin_r     <= coin_next;
      req_ready  <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);
      err        <= (state_next == DONE) && err_next;
      rem_out    <= rem_next;
      dime_out   <= (state_next == PULSE) && (coin_next == COIN_D);
      nickel_out <= (state_next == PULSE) && (coin_next == COIN_N);
    end
  end

`ifdef CHANGE_DISPENSER_QUARTER_EN
  // Quarter solenoid drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quarter_out <= 1'b0;
    end else begin
      quarter_out <= (state_next == PULSE) && (coin_next == COIN_Q);
    end
  end
`else
  logic unused_quarter_empty;
  assign unused_quarter_empty = quarter_empty;
  assign quarter_out          = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int PC    = 4;
  localparam int GC    = 2;
  localparam int COST  = 1 + PC + GC;

  localparam logic [2:0] CQ = 3'b100;
  localparam logic [2:0] CD = 3'b010;
  localparam logic [2:0] CN = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount = '0;
  logic             quarter_empty = 1'b0;
  logic             dime_empty = 1'b0;
  logic             nickel_empty = 1'b0;
  logic             quarter_out, dime_out, nickel_out;
  logic             busy, done, err;
  logic [AMT_W-1:0] rem_out;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYCLES(PC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
    .quarter_empty(quarter_empty), .dime_empty(dime_empty), .nickel_empty(nickel_empty),
    .quarter_out(quarter_out), .dime_out(dime_out), .nickel_out(nickel_out),
    .busy(busy), .done(done), .err(err), .rem_out(rem_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " coins"}, 32'({quarter_out, dime_out, nickel_out}), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " rem_out"}, 32'(rem_out), 32'd0);
  endtask

  // Issue one request and follow it to done. Expected coins must already be
  // in exp_q; t counts sample points, t=1 being the SELECT cycle.
  task automatic dispense(input string tag, input logic [AMT_W-1:0] amt, input int ncoins,
                          input logic e_err, input logic [AMT_W-1:0] e_rem);
    logic [2:0] cur, prev, want;
    int idx, hi_len;
    bit seen_done;
    idx = 0; hi_len = 0; prev = 3'b000; seen_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = amt;
    chk({tag, " ready before accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int t = 1; t <= 200 && !seen_done; t++) begin
      @(negedge clk);
      req_valid = 1'b0;
      cur = {quarter_out, dime_out, nickel_out};
      chk({tag, " onehot"}, 32'($countones(cur) <= 1), 32'd1);
      if (cur != 3'b000 && prev == 3'b000) begin
        chk({tag, " coin rise time"}, 32'(t), 32'(2 + COST * idx));
        if (exp_q.size() == 0) begin
          chk({tag, " unexpected coin"}, 32'(cur), 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk({tag, " coin kind"}, 32'(cur), 32'(want));
        end
        idx++;
        hi_len = 1;
      end else if (cur != 3'b000) begin
        chk({tag, " coin steady"}, 32'(cur), 32'(prev));
        hi_len++;
      end else if (prev != 3'b000) begin
        chk({tag, " pulse width"}, 32'(hi_len), 32'(PC));
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, " done time"}, 32'(t), 32'(COST * ncoins + 2));
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " rem_out"}, 32'(rem_out), 32'(e_rem));
        chk({tag, " coin count"}, 32'(idx), 32'(ncoins));
        chk({tag, " ready during done"}, 32'(req_ready), 32'd0);
      end
      prev = cur;
    end
    chk({tag, " done seen"}, 32'(seen_done), 32'd1);
    chk({tag, " queue drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, " ready after done"}, 32'(req_ready), 32'd1);
    chk({tag, " done is strobe"}, 32'(done), 32'd0);
    chk({tag, " busy after done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int accepts, rises, first_ready;
    logic [2:0] prev;
    bit finished;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post reset");

    // Amount 8, all tubes full
`ifdef CHANGE_DISPENSER_QUARTER_EN
    exp_q.push_back(CQ); exp_q.push_back(CD); exp_q.push_back(CN);
    dispense("amt8", 4'd8, 3, 1'b0, 4'd0);
`else
    repeat (4) exp_q.push_back(CD);
    dispense("amt8", 4'd8, 4, 1'b0, 4'd0);
`endif

    // Amount 0: no coins, done at t=2, ready at t=3
    dispense("amt0", 4'd0, 0, 1'b0, 4'd0);

    // Amount 5 with the quarter tube empty
    quarter_empty = 1'b1;
    exp_q.push_back(CD); exp_q.push_back(CD); exp_q.push_back(CN);
    dispense("amt5 qempty", 4'd5, 3, 1'b0, 4'd0);
    quarter_empty = 1'b0;

    // Amount 5 all tubes full
`ifdef CHANGE_DISPENSER_QUARTER_EN
    exp_q.push_back(CQ);
    dispense("amt5 full", 4'd5, 1, 1'b0, 4'd0);
`else
    exp_q.push_back(CD); exp_q.push_back(CD); exp_q.push_back(CN);
    dispense("amt5 full", 4'd5, 3, 1'b0, 4'd0);
`endif

    // Amount 3 with nickels empty: one dime, then error with 1 left
    nickel_empty = 1'b1;
    exp_q.push_back(CD);
    dispense("amt3 nempty", 4'd3, 1, 1'b1, 4'd1);
    nickel_empty = 1'b0;

    // Amount 7 with dimes empty
    dime_empty = 1'b1;
`ifdef CHANGE_DISPENSER_QUARTER_EN
    exp_q.push_back(CQ); exp_q.push_back(CN); exp_q.push_back(CN);
    dispense("amt7 dempty", 4'd7, 3, 1'b0, 4'd0);
`else
    repeat (7) exp_q.push_back(CN);
    dispense("amt7 dempty", 4'd7, 7, 1'b0, 4'd0);
`endif
    dime_empty = 1'b0;

    // Amount 1 with every tube empty: immediate error
    quarter_empty = 1'b1; dime_empty = 1'b1; nickel_empty = 1'b1;
    dispense("amt1 allempty", 4'd1, 0, 1'b1, 4'd1);
    quarter_empty = 1'b0; dime_empty = 1'b0; nickel_empty = 1'b0;

    // Busy: valid held high through an amount-2 dispense
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = 4'd2;
    @(posedge clk);
    accepts = 0; rises = 0; first_ready = 0; prev = 3'b000;
    for (int t = 1; t <= 40 && first_ready == 0; t++) begin
      @(negedge clk);
      if ({quarter_out, dime_out, nickel_out} != 3'b000 && prev == 3'b000) rises++;
      prev = {quarter_out, dime_out, nickel_out};
      if (req_ready) first_ready = t;
    end
    chk("busy single coin", 32'(rises), 32'd1);
    chk("busy ready returns", 32'(first_ready), 32'(COST + 3));
    @(negedge clk);
    chk("busy reaccept busy", 32'(busy), 32'd1);
    chk("busy reaccept ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    finished = 1'b0;
    for (int t = 0; t < 40 && !finished; t++) begin
      @(negedge clk);
      if (done) finished = 1'b1;
    end
    chk("busy second done", 32'(finished), 32'd1);
    chk("busy second err", 32'(err), 32'd0);
    @(negedge clk);
    chk("busy idle again", 32'(req_ready), 32'd1);

    // Reset during the second cycle of a pulse
    @(negedge clk);
    req_valid = 1'b1;
`ifdef CHANGE_DISPENSER_QUARTER_EN
    req_amount = 4'd5;
`else
    req_amount = 4'd2;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef CHANGE_DISPENSER_QUARTER_EN
    chk("rst pulse active", 32'(quarter_out), 32'd1);
`else
    chk("rst pulse active", 32'(dime_out), 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async coins", 32'({quarter_out, dime_out, nickel_out}), 32'd0);
    chk_idle("rst async");
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if ({quarter_out, dime_out, nickel_out} != 3'b000) rises++;
    end
    chk("rst no resume", 32'(rises), 32'd0);
    chk_idle("rst after release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return transmitter for the vending-machine path: the counterpart of the coin-accepting state machine. It accepts a change amount in nickel units over a valid/ready handshake and drives the coin-return solenoids. Each coin is a timed pulse on `quarter_out`, `dime_out` or `nickel_out`. Coins are chosen greedily, the largest first, and the chooser falls back to smaller coins when a tube reports empty.

## Interface
- `AMT_W`, default 4: width of the requested amount, in nickel units (5 cents each).
- `PULSE_CYCLES`, default 4: solenoid on-time per coin in clocks; must be ≥1.
- `GAP_CYCLES`, default 2: mandatory low time after each pulse in clocks; must be ≥1.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  change request present.
- `req_ready`  out  1  high only in IDLE.
- `req_amount`  in  AMT_W  change owed, in nickels; sampled on accept.
- `quarter_empty`, `dime_empty`, `nickel_empty`  in  1 each  tube-empty flags; sampled only in SELECT.
- `quarter_out`, `dime_out`, `nickel_out`  out  1 each  registered solenoid drives; at most one is high at a time.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion strobe.
- `err`  out  1  valid with `done`: 1 means change could not be completed.
- `rem_out`  out  AMT_W  remaining undispensed amount; valid with `done`, otherwise equal to the internal remainder.

## Operation
- **Reset values.** All outputs are 0 except `req_ready`, which is 1. The state is IDLE and the remainder is 0.
- **States.** IDLE, SELECT, PULSE, GAP, DONE.
- **IDLE.** When `req_valid && req_ready`, latch `req_amount` into the remainder and go to SELECT.
- **SELECT** (one cycle) checks the following rules in order:
  - remainder == 0 → DONE with `err`=0.
  - `QUARTER_EN` defined, remainder ≥5 and `!quarter_empty` → coin is quarter.
  - else remainder ≥2 and `!dime_empty` → coin is dime.
  - else remainder ≥1 and `!nickel_empty` → coin is nickel.
  - else → DONE with `err`=1.
  - When a coin is chosen, subtract its value (Q=5, D=2, N=1) from the remainder and go to PULSE.
- **Remainder arithmetic.** The subtraction cannot underflow, because a coin is chosen only when its value ≤ remainder. The remainder is AMT_W bits wide.
- **PULSE.** The selected `*_out` is high for exactly `PULSE_CYCLES` clocks, then the block goes to GAP.
- **GAP.** All coin outputs are low for `GAP_CYCLES` clocks, then the block returns to SELECT.
- **DONE** (one cycle): `done`=1, `err` and `rem_out` are valid. The next state is IDLE.
- **Empty-flag timing.** Changes to the empty flags during PULSE or GAP are ignored until the next SELECT.
- **Requests while busy.** `req_valid` asserted while busy is not accepted and is not queued; `req_ready` is 0.
- **Reset mid-operation.** Coin outputs drop immediately (asynchronous). The remainder is lost and no pulse resumes after reset is released.

## Timing
- **Acceptance.** A request is accepted at clock edge k, and SELECT occupies cycle k+1.
- **Coin pulse.** The first coin output rises at edge k+2.
- **Per-coin cost.** Each coin costs 1 + `PULSE_CYCLES` + `GAP_CYCLES` cycles (7 at defaults).
- **Completion.** `done` follows the final SELECT by one cycle. `req_ready` is high again in the cycle after `done`.
- **Zero amount.** A request of 0 gives `done` at cycle k+2, with no coin pulse.
- **Output registration.** All outputs are registered, with no combinational path from input to output.

## Configuration
- **Macro:** `CHANGE_DISPENSER_QUARTER_EN`.
- **Defined:** the quarter branch exists in SELECT, and `quarter_out` is driven as specified.
- **Undefined:** `quarter_out` is tied to 0 and `quarter_empty` is ignored. Only dimes and nickels are dispensed; for example, amount 5 is dispensed as D, D, N.

## Structure
- **Package `coin_pkg`:**
  - constants `NICKEL_UNITS`=1, `DIME_UNITS`=2, `QUARTER_UNITS`=5;
  - state enum `disp_state_t` {IDLE, SELECT, PULSE, GAP, DONE};
  - coin enum `coin_t` {COIN_N, COIN_D, COIN_Q}.
- **Sub-module `pulse_timer`:** a down-counter loaded with `PULSE_CYCLES` or `GAP_CYCLES` that asserts `expire` on its last cycle. It is shared by the PULSE and GAP states.
- The counter width is `$clog2(max(PULSE_CYCLES, GAP_CYCLES)+1)`.

## Test plan
- **Amount 8, all tubes full, quarter enabled:** coins Q, D, N in that order, each pulse 4 cycles with a 2-cycle gap. `done` at k+23 with `err`=0 and `rem_out`=0.
- **Amount 0:** no coin pulse. `done` at k+2 with `err`=0. `req_ready` high at k+3.
- **Amount 5 with `quarter_empty`=1:** coins D, D, N; `err`=0. The same sequence results with the macro undefined and all tubes full.
- **Amount 3 with `nickel_empty`=1:** one D pulse, then `done` with `err`=1 and `rem_out`=1.
- **Busy behaviour:** `req_valid` held high throughout an amount-2 dispense is accepted only once, and accepted again the cycle after returning to IDLE.
- **Reset mid-PULSE:** `rst_n` low during the second cycle of a quarter pulse. `quarter_out` drops without waiting for a clock edge, and all outputs take reset values. After release there is no further pulse, and `req_ready` is 1.
